// File: rtl/mem_resp_queue_stage.sv
// In-order memory stage queue: holds up to DEPTH EX-stage instructions with outstanding
// data-bus responses, steers responses to the oldest waiting entry and retires in order to WB.
module mem_resp_queue_stage #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          es_to_ms_valid,
    output logic          ms_allowin,
    input  logic          es_need_data,
    input  logic          es_res_from_mem,
    input  logic [3:0]    es_mem_num,
    input  logic          es_sign_ext,
    input  logic          es_merge_l,
    input  logic          es_merge_r,
    input  logic [31:0]   es_rt_value,
    input  logic [31:0]   es_alu_result,
    input  logic          es_gr_we,
    input  logic [4:0]    es_dest,
    input  logic [31:0]   es_pc,
    input  logic          es_ex,
    input  logic          data_data_ok,
    input  logic [31:0]   data_rdata,
    input  logic          ws_allowin,
    input  logic          flush,
    output logic          ms_to_ws_valid,
    output logic [31:0]   ms_final_result,
    output logic          ms_gr_we,
    output logic [4:0]    ms_dest,
    output logic [31:0]   ms_pc,
    output logic          ms_ex,
    output logic [CW-1:0] ms_count,
    output logic [CW-1:0] ms_discard,
    output logic          ms_resp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        res_from_mem;
        logic [3:0]  mem_num;
        logic        sign_ext;
        logic        merge_l;
        logic        merge_r;
        logic [31:0] rt_value;
        logic [31:0] alu_result;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        ex;
    } entry_t;

    entry_t           ent_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg, need_reg, have_reg;
    logic [AW-1:0]    head_reg, tail_reg;
    logic [CW-1:0]    count_reg, discard_reg;
    logic             err_reg;

    logic [AW-1:0]    off_idx [DEPTH];
    logic [CW-1:0]    pending;
    logic [CW-1:0]    pending_after;
    logic [AW-1:0]    resp_idx;
    logic             resp_found, resp_to_entry, resp_to_discard, resp_stray;
    logic             head_ready, push, pop;
    logic [CW:0]      occupancy;
    entry_t           head_ent, ent_in;
    logic [31:0]      head_data, final_result;

    // Physical index of the entry i positions behind the head (program order).
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_off
            assign off_idx[gi] = head_reg + AW'(gi);
        end
    endgenerate

    // Youngest-to-oldest scan so the last hit is the oldest waiting entry.
    always_comb begin
        resp_found = 1'b0;
        resp_idx   = head_reg;
        pending    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_reg[i] && need_reg[i] && !have_reg[i])
                pending = pending + CW'(1);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_reg[off_idx[i]] && need_reg[off_idx[i]] && !have_reg[off_idx[i]]) begin
                resp_found = 1'b1;
                resp_idx   = off_idx[i];
            end
        end
    end

    assign resp_to_discard = data_data_ok && (discard_reg != '0);
    assign resp_to_entry   = data_data_ok && (discard_reg == '0) && resp_found;
    assign resp_stray      = data_data_ok && (discard_reg == '0) && !resp_found;
    // A response that lands on an entry killed by this flush is lost, not owed.
    assign pending_after   = pending - CW'(resp_to_entry);

    assign head_ready = valid_reg[head_reg] &&
                        (!need_reg[head_reg] || have_reg[head_reg] ||
                         (resp_to_entry && resp_idx == head_reg));
    assign occupancy      = {1'b0, count_reg} + {1'b0, discard_reg};
    assign ms_allowin     = !flush && (occupancy < (CW+1)'(DEPTH));
    assign ms_to_ws_valid = head_ready && !flush;
    assign push           = es_to_ms_valid && ms_allowin;
    assign pop            = ms_to_ws_valid && ws_allowin;

    assign ent_in = '{res_from_mem: es_res_from_mem, mem_num: es_mem_num,
                      sign_ext: es_sign_ext, merge_l: es_merge_l, merge_r: es_merge_r,
                      rt_value: es_rt_value, alu_result: es_alu_result, gr_we: es_gr_we,
                      dest: es_dest, pc: es_pc, ex: es_ex};

    always_comb begin
        head_ent     = ent_mem[head_reg];
        head_data    = have_reg[head_reg] ? data_mem[head_reg] : data_rdata;
        final_result = head_ent.alu_result;
        if (head_ent.merge_l) begin
            case (head_ent.mem_num)
                4'b0001: final_result = {head_data[7:0],  head_ent.rt_value[23:0]};
                4'b0011: final_result = {head_data[15:0], head_ent.rt_value[15:0]};
                4'b0111: final_result = {head_data[23:0], head_ent.rt_value[7:0]};
                default: final_result = head_data;
            endcase
        end else if (head_ent.merge_r) begin
            case (head_ent.mem_num)
                4'b1000: final_result = {head_ent.rt_value[31:8],  head_data[31:24]};
                4'b1100: final_result = {head_ent.rt_value[31:16], head_data[31:16]};
                4'b1110: final_result = {head_ent.rt_value[31:24], head_data[31:8]};
                default: final_result = head_data;
            endcase
        end else if (head_ent.res_from_mem) begin
            case (head_ent.mem_num)
                4'b0001: final_result = {{24{head_ent.sign_ext & head_data[7]}},  head_data[7:0]};
                4'b0010: final_result = {{24{head_ent.sign_ext & head_data[15]}}, head_data[15:8]};
                4'b0100: final_result = {{24{head_ent.sign_ext & head_data[23]}}, head_data[23:16]};
                4'b1000: final_result = {{24{head_ent.sign_ext & head_data[31]}}, head_data[31:24]};
                4'b0011: final_result = {{16{head_ent.sign_ext & head_data[15]}}, head_data[15:0]};
                4'b1100: final_result = {{16{head_ent.sign_ext & head_data[31]}}, head_data[31:16]};
                default: final_result = head_data;
            endcase
        end
    end

    assign ms_final_result = final_result;
    assign ms_gr_we        = head_ent.gr_we;
    assign ms_dest         = head_ent.dest;
    assign ms_pc           = head_ent.pc;
    assign ms_ex           = head_ent.ex;
    assign ms_count        = count_reg;
    assign ms_discard      = discard_reg;
    assign ms_resp_err     = err_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_reg   <= '0;
            need_reg    <= '0;
            have_reg    <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            discard_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            if (resp_stray)
                err_reg <= 1'b1;
            if (flush) begin
                valid_reg   <= '0;
                head_reg    <= '0;
                tail_reg    <= '0;
                count_reg   <= '0;
                discard_reg <= discard_reg - CW'(resp_to_discard) + pending_after;
            end else begin
                if (resp_to_discard)
                    discard_reg <= discard_reg - CW'(1);
                if (resp_to_entry)
                    have_reg[resp_idx] <= 1'b1;
                if (pop) begin
                    valid_reg[head_reg] <= 1'b0;
                    head_reg            <= head_reg + AW'(1);
                end
                if (push) begin
                    valid_reg[tail_reg] <= 1'b1;
                    need_reg[tail_reg]  <= es_need_data && !es_ex;
                    have_reg[tail_reg]  <= 1'b0;
                    tail_reg            <= tail_reg + AW'(1);
                end
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            ent_mem[tail_reg] <= ent_in;
        if (resp_to_entry)
            data_mem[resp_idx] <= data_rdata;
    end
endmodule

// File: tb/tb_mem_resp_queue_stage.sv
// Bench for mem_resp_queue_stage: directed result-selection table, multi-cycle corner
// sequences and a randomized run against a queue-based reference model.
module tb_mem_resp_queue_stage;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          es_to_ms_valid, ms_allowin, es_need_data, es_res_from_mem;
    logic [3:0]    es_mem_num;
    logic          es_sign_ext, es_merge_l, es_merge_r;
    logic [31:0]   es_rt_value, es_alu_result, es_pc;
    logic          es_gr_we, es_ex;
    logic [4:0]    es_dest;
    logic          data_data_ok;
    logic [31:0]   data_rdata;
    logic          ws_allowin, flush;
    logic          ms_to_ws_valid, ms_gr_we, ms_ex, ms_resp_err;
    logic [31:0]   ms_final_result, ms_pc;
    logic [4:0]    ms_dest;
    logic [CW-1:0] ms_count, ms_discard;

    int n_checks = 0;
    int n_fail   = 0;

    mem_resp_queue_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_need_data(es_need_data), .es_res_from_mem(es_res_from_mem),
        .es_mem_num(es_mem_num), .es_sign_ext(es_sign_ext),
        .es_merge_l(es_merge_l), .es_merge_r(es_merge_r),
        .es_rt_value(es_rt_value), .es_alu_result(es_alu_result),
        .es_gr_we(es_gr_we), .es_dest(es_dest), .es_pc(es_pc), .es_ex(es_ex),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .ws_allowin(ws_allowin), .flush(flush),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_final_result(ms_final_result),
        .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_pc(ms_pc), .ms_ex(ms_ex),
        .ms_count(ms_count), .ms_discard(ms_discard), .ms_resp_err(ms_resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mem_num;
        logic        sext, ml, mr, rfm;
        logic [31:0] rt, alu, rdata, exp;
    } vec_t;

    typedef struct {
        logic        need, have;
        logic [31:0] data, rt, alu, pc;
        logic [3:0]  mem_num;
        logic        sext, ml, mr, rfm, gr_we, ex;
        logic [4:0]  dest;
    } m_ent_t;

    vec_t   vt [15];
    m_ent_t mq [$];
    int     discard_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid = 0; es_need_data = 0; es_res_from_mem = 0; es_mem_num = 4'hF;
        es_sign_ext = 0; es_merge_l = 0; es_merge_r = 0; es_rt_value = 0;
        es_alu_result = 0; es_gr_we = 0; es_dest = 0; es_pc = 0; es_ex = 0;
        data_data_ok = 0; data_rdata = 0; ws_allowin = 0; flush = 0;
    endtask

    task automatic put_load(input logic [3:0] mn);
        es_to_ms_valid = 1; es_need_data = 1; es_res_from_mem = 1; es_mem_num = mn;
        es_gr_we = 1; es_dest = 5'd3;
    endtask

    // Specification-level result rules expressed as lane arithmetic.
    function automatic logic [31:0] ref_result(input m_ent_t e, input logic [31:0] d);
        int n, lo;
        logic [63:0] v, m;
        n  = $countones(e.mem_num);
        lo = 0;
        while (lo < 4 && !e.mem_num[lo]) lo++;
        if (e.ml) begin
            v = {32'b0, d} << (8 * (4 - n));
            m = (64'd1 << (8 * (4 - n))) - 64'd1;
            return v[31:0] | (e.rt & m[31:0]);
        end
        if (e.mr) begin
            v = {32'b0, d} >> (8 * (4 - n));
            m = (64'd1 << (8 * n)) - 64'd1;
            return v[31:0] | (e.rt & ~m[31:0]);
        end
        if (e.rfm) begin
            m = (64'd1 << (8 * n)) - 64'd1;
            v = ({32'b0, d} >> (8 * lo)) & m;
            if (e.sext && n < 4 && v[8 * n - 1]) v = v | ~m;
            return v[31:0];
        end
        return e.alu;
    endfunction

    task automatic rand_entry(output m_ent_t e);
        int kind;
        kind = $urandom_range(0, 5);
        e.rt = $urandom; e.alu = $urandom; e.pc = $urandom;
        e.dest = 5'($urandom); e.gr_we = 1'($urandom);
        e.ex = ($urandom_range(0, 15) == 0);
        e.ml = 0; e.mr = 0; e.rfm = 0; e.sext = 1'($urandom); e.mem_num = 4'hF;
        e.need = (kind >= 2);
        case (kind)
            3: begin
                e.rfm = 1;
                case ($urandom_range(0, 6))
                    0: e.mem_num = 4'b0001; 1: e.mem_num = 4'b0010;
                    2: e.mem_num = 4'b0100; 3: e.mem_num = 4'b1000;
                    4: e.mem_num = 4'b0011; 5: e.mem_num = 4'b1100;
                    default: e.mem_num = 4'b1111;
                endcase
            end
            4: begin
                e.ml = 1; e.rfm = 1;
                case ($urandom_range(0, 3))
                    0: e.mem_num = 4'b0001; 1: e.mem_num = 4'b0011;
                    2: e.mem_num = 4'b0111; default: e.mem_num = 4'b1111;
                endcase
            end
            5: begin
                e.mr = 1; e.rfm = 1;
                case ($urandom_range(0, 3))
                    0: e.mem_num = 4'b1000; 1: e.mem_num = 4'b1100;
                    2: e.mem_num = 4'b1110; default: e.mem_num = 4'b1111;
                endcase
            end
            default: ;
        endcase
        e.have = 0; e.data = 0;
    endtask

    initial begin
        vt[0]  = '{4'b0010, 1, 0, 0, 1, 32'h0, 32'h0, 32'h0000_8000, 32'hFFFF_FF80};
        vt[1]  = '{4'b0010, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0000_8000, 32'h0000_0080};
        vt[2]  = '{4'b0001, 1, 0, 0, 1, 32'h0, 32'h0, 32'h1234_5678, 32'h0000_0078};
        vt[3]  = '{4'b1000, 1, 0, 0, 1, 32'h0, 32'h0, 32'h8765_4321, 32'hFFFF_FF87};
        vt[4]  = '{4'b0011, 1, 0, 0, 1, 32'h0, 32'h0, 32'h1234_8001, 32'hFFFF_8001};
        vt[5]  = '{4'b1100, 0, 0, 0, 1, 32'h0, 32'h0, 32'h8001_1234, 32'h0000_8001};
        vt[6]  = '{4'b1111, 1, 0, 0, 1, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[7]  = '{4'b0011, 0, 1, 0, 1, 32'hAABB_CCDD, 32'h0, 32'h1234_5678, 32'h5678_CCDD};
        vt[8]  = '{4'b1100, 0, 0, 1, 1, 32'hAABB_CCDD, 32'h0, 32'h1234_5678, 32'hAABB_1234};
        vt[9]  = '{4'b0001, 0, 1, 0, 1, 32'hAABB_CCDD, 32'h0, 32'h1234_5678, 32'h78BB_CCDD};
        vt[10] = '{4'b1000, 0, 0, 1, 1, 32'hAABB_CCDD, 32'h0, 32'h1234_5678, 32'hAABB_CC12};
        vt[11] = '{4'b0111, 0, 1, 0, 1, 32'hAABB_CCDD, 32'h0, 32'h1234_5678, 32'h3456_78DD};
        vt[12] = '{4'b1110, 0, 0, 1, 1, 32'hAABB_CCDD, 32'h0, 32'h1234_5678, 32'hAA12_3456};
        vt[13] = '{4'b1111, 0, 0, 0, 0, 32'h0, 32'h1000_0040, 32'h5555_5555, 32'h1000_0040};
        vt[14] = '{4'b0100, 1, 0, 0, 1, 32'h0, 32'h0, 32'h0080_0000, 32'hFFFF_FF80};

        idle();
        resetn = 0;
        #2;
        chk("reset_count", 32'(ms_count), 0);
        chk("reset_discard", 32'(ms_discard), 0);
        chk("reset_err", 32'(ms_resp_err), 0);
        chk("reset_valid", 32'(ms_to_ws_valid), 0);
        chk("reset_allowin", 32'(ms_allowin), 1);
        step();
        resetn = 1;

        // Result selection table; each load completes via the same-cycle bypass.
        for (int i = 0; i < 15; i++) begin
            step(); idle();
            es_to_ms_valid = 1; es_need_data = 1; es_res_from_mem = vt[i].rfm;
            es_mem_num = vt[i].mem_num; es_sign_ext = vt[i].sext;
            es_merge_l = vt[i].ml; es_merge_r = vt[i].mr;
            es_rt_value = vt[i].rt; es_alu_result = vt[i].alu;
            #1;
            chk($sformatf("vec%0d_allowin", i), 32'(ms_allowin), 1);
            step(); idle();
            data_data_ok = 1; data_rdata = vt[i].rdata; ws_allowin = 1;
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(ms_to_ws_valid), 1);
            chk($sformatf("vec%0d_result", i), ms_final_result, vt[i].exp);
        end

        // Non-memory entry: visible the cycle after enqueue.
        step(); idle();
        es_to_ms_valid = 1; es_alu_result = 32'hCAFE_0001; es_gr_we = 1;
        es_dest = 5'd17; es_pc = 32'hBFC0_0100; ws_allowin = 1;
        #1;
        chk("alu_valid_same_cycle", 32'(ms_to_ws_valid), 0);
        step(); idle(); ws_allowin = 1;
        #1;
        chk("alu_valid_next", 32'(ms_to_ws_valid), 1);
        chk("alu_result", ms_final_result, 32'hCAFE_0001);
        chk("alu_dest", 32'(ms_dest), 17);
        chk("alu_pc", ms_pc, 32'hBFC0_0100);
        chk("alu_gr_we", 32'(ms_gr_we), 1);

        // Four back-to-back loads, then four consecutive responses.
        for (int k = 0; k < 4; k++) begin
            step(); idle(); put_load(4'hF); es_pc = 32'(k);
            #1;
            chk($sformatf("burst_allowin%0d", k), 32'(ms_allowin), 1);
        end
        step(); idle(); es_to_ms_valid = 1; es_need_data = 1;
        #1;
        chk("full_count", 32'(ms_count), 4);
        chk("full_allowin", 32'(ms_allowin), 0);
        for (int k = 0; k < 4; k++) begin
            step(); idle();
            data_data_ok = 1; data_rdata = 32'h11 * (k + 1); ws_allowin = 1;
            #1;
            chk($sformatf("burst_count%0d", k), 32'(ms_count), 32'(4 - k));
            chk($sformatf("burst_valid%0d", k), 32'(ms_to_ws_valid), 1);
            chk($sformatf("burst_result%0d", k), ms_final_result, 32'h11 * (k + 1));
            chk($sformatf("burst_pc%0d", k), ms_pc, 32'(k));
        end
        step(); idle(); #1;
        chk("burst_empty", 32'(ms_count), 0);

        // Flush with three loads outstanding; their responses must be swallowed.
        for (int k = 0; k < 3; k++) begin
            step(); idle(); put_load(4'hF);
        end
        step(); idle(); flush = 1; ws_allowin = 1;
        #1;
        chk("flush_allowin", 32'(ms_allowin), 0);
        for (int k = 0; k < 3; k++) begin
            step(); idle(); data_data_ok = 1; data_rdata = 32'hDEAD; ws_allowin = 1;
            #1;
            chk($sformatf("drop_discard%0d", k), 32'(ms_discard), 32'(3 - k));
            chk($sformatf("drop_valid%0d", k), 32'(ms_to_ws_valid), 0);
        end
        step(); idle(); put_load(4'hF);
        #1;
        chk("drop_done", 32'(ms_discard), 0);
        step(); idle(); data_data_ok = 1; data_rdata = 32'hBEEF; ws_allowin = 1;
        #1;
        chk("beef_valid", 32'(ms_to_ws_valid), 1);
        chk("beef_result", ms_final_result, 32'hBEEF);
        step(); idle(); #1;
        chk("beef_err", 32'(ms_resp_err), 0);
        chk("beef_count", 32'(ms_count), 0);

        // Flush coinciding with a discarded response while two loads are pending.
        step(); idle(); put_load(4'hF);
        step(); idle(); flush = 1;
        step(); idle(); put_load(4'hF);
        #1;
        chk("cflush_discard1", 32'(ms_discard), 1);
        step(); idle(); put_load(4'hF);
        step(); idle(); flush = 1; data_data_ok = 1; data_rdata = 32'h77;
        #1;
        chk("cflush_count", 32'(ms_count), 2);
        step(); idle(); data_data_ok = 1;
        #1;
        chk("cflush_discard2", 32'(ms_discard), 2);
        step(); idle(); data_data_ok = 1;
        step(); idle(); #1;
        chk("cflush_discard0", 32'(ms_discard), 0);
        chk("cflush_err", 32'(ms_resp_err), 0);

        // Randomized traffic against the reference model.
        mq.delete();
        discard_m = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int pend, tgt;
            logic exp_allow, exp_v, cons;
            logic [31:0] hd;
            m_ent_t ne;
            step(); idle();
            pend = 0;
            foreach (mq[i]) if (mq[i].need && !mq[i].have) pend++;
            rand_entry(ne);
            es_to_ms_valid = ($urandom_range(0, 2) != 0);
            es_need_data = ne.need; es_res_from_mem = ne.rfm; es_mem_num = ne.mem_num;
            es_sign_ext = ne.sext; es_merge_l = ne.ml; es_merge_r = ne.mr;
            es_rt_value = ne.rt; es_alu_result = ne.alu; es_gr_we = ne.gr_we;
            es_dest = ne.dest; es_pc = ne.pc; es_ex = ne.ex;
            ne.need = ne.need && !ne.ex;
            flush = ($urandom_range(0, 24) == 0);
            ws_allowin = ($urandom_range(0, 3) != 0);
            data_data_ok = (discard_m + pend > 0) && ($urandom_range(0, 1) == 1);
            data_rdata = $urandom;
            #1;
            exp_allow = !flush && (mq.size() + discard_m < DEPTH);
            tgt = -1;
            if (data_data_ok && discard_m == 0)
                for (int i = mq.size() - 1; i >= 0; i--)
                    if (mq[i].need && !mq[i].have) tgt = i;
            exp_v = !flush && mq.size() > 0 && (!mq[0].need || mq[0].have || tgt == 0);
            chk("rnd_allowin", 32'(ms_allowin), 32'(exp_allow));
            chk("rnd_valid", 32'(ms_to_ws_valid), 32'(exp_v));
            chk("rnd_count", 32'(ms_count), 32'(mq.size()));
            chk("rnd_discard", 32'(ms_discard), 32'(discard_m));
            chk("rnd_err", 32'(ms_resp_err), 0);
            if (exp_v) begin
                chk("rnd_ex", 32'(ms_ex), 32'(mq[0].ex));
                chk("rnd_pc", ms_pc, mq[0].pc);
                chk("rnd_dest", 32'(ms_dest), 32'(mq[0].dest));
                if (!mq[0].ex) begin
                    hd = mq[0].have ? mq[0].data : data_rdata;
                    chk("rnd_result", ms_final_result, ref_result(mq[0], hd));
                    chk("rnd_gr_we", 32'(ms_gr_we), 32'(mq[0].gr_we));
                end
            end
            cons = data_data_ok && discard_m > 0;
            if (flush) begin
                discard_m = discard_m - int'(cons) + pend - ((tgt >= 0) ? 1 : 0);
                mq.delete();
            end else begin
                if (cons) discard_m--;
                else if (tgt >= 0) begin
                    mq[tgt].have = 1;
                    mq[tgt].data = data_rdata;
                end
                if (exp_v && ws_allowin) void'(mq.pop_front());
                if (es_to_ms_valid && exp_allow) mq.push_back(ne);
            end
        end

        // Clear leftovers, then a stray response must set the sticky error.
        step(); idle(); resetn = 0;
        step(); resetn = 1;
        step(); idle(); data_data_ok = 1; data_rdata = 32'h1;
        step(); idle(); #1;
        chk("stray_err", 32'(ms_resp_err), 1);
        repeat (5) step();
        chk("stray_sticky", 32'(ms_resp_err), 1);
        resetn = 0;
        #1;
        chk("stray_reset", 32'(ms_resp_err), 0);
        chk("stray_reset_allowin", 32'(ms_allowin), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
